// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Shared definitions for the RV32I pipeline front end.
//   XLEN          : datapath / PC width
//   NOP_INSTR     : bubble encoding (addi x0,x0,0)
//   RESET_PC      : default PC after reset
//   fetch_state_e : instruction-fetch FSM states
// ---------------------------------------------------------------------------
package core_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    // REQ  : request presented on the instruction-memory port
    // WAIT : request accepted, waiting for the response
    // FULL : response captured in the local buffer, waiting for decode
    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_FULL = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register carrying the fetched instruction to decode.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   stall_i         : hold every output (wins over flush_i)
//   flush_i         : load a bubble
//   load_i          : load instr_i / pc_i / pc_plus4_i as a valid instruction
//   instr_i, pc_i, pc_plus4_i : incoming instruction and its PCs
//   instr_o, pc_o, pc_plus4_o, valid_o : registered decode-stage values
// When neither stalled, flushed nor loaded, a bubble is inserted. Bubbles
// leave the PC fields untouched since decode ignores them when valid_o=0.
// ---------------------------------------------------------------------------
module if_id_reg #(
    parameter int          XLEN      = core_pkg::XLEN,
    parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            load_i,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] pc_plus4_i,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            valid_o
);

    logic [31:0]     instr_q;
    logic [31:0]     instr_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pc_plus4_q;
    logic [XLEN-1:0] pc_plus4_d;
    logic            valid_q;
    logic            valid_d;

    always_comb begin
        instr_d    = instr_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (stall_i) begin
            // hold everything
        end else if (flush_i || !load_i) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else begin
            instr_d    = instr_i;
            pc_d       = pc_i;
            pc_plus4_d = pc_plus4_i;
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_q    <= NOP_INSTR;
            pc_q       <= '0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign instr_o    = instr_q;
    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction fetch + IF/ID register for the 5-stage RV32I core.
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   StallF, StallD       : hold PCF / hold IF/ID
//   FlushD               : load a bubble into IF/ID
//   PCSrcE, PCTargetE    : redirect from execute
//   imem_req, imem_addr  : request to instruction memory (word aligned)
//   imem_ready           : memory accepts the request this cycle
//   imem_rvalid, imem_rdata : response from instruction memory
//   InstrD, PCD, PCPlus4D, ValidD : decode-stage outputs
// One request at most is outstanding. A response belonging to a request
// issued before a redirect is dropped using the discard flag.
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter int          XLEN      = core_pkg::XLEN,
    parameter logic [31:0] RESET_PC  = core_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
);

    import core_pkg::fetch_state_e;
    import core_pkg::FETCH_REQ;
    import core_pkg::FETCH_WAIT;
    import core_pkg::FETCH_FULL;

    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    fetch_state_e    state_q;
    fetch_state_e    state_d;
    logic [XLEN-1:0] pcf_q;
    logic [XLEN-1:0] pcf_d;
    logic            discard_q;
    logic            discard_d;
    logic [31:0]     buf_instr_q;
    logic [31:0]     buf_instr_d;

    logic            avail;
    logic            transfer;
    logic [31:0]     src_instr;
    logic [XLEN-1:0] pcf_plus4;

    // An instruction is available either from the buffer or straight from a
    // response that is not being discarded.
    assign avail     = (state_q == FETCH_FULL) ||
                       ((state_q == FETCH_WAIT) && imem_rvalid && !discard_q);
    assign src_instr = (state_q == FETCH_FULL) ? buf_instr_q : imem_rdata;
    assign pcf_plus4 = pcf_q + PC_STEP;

    // The available instruction is consumed whenever decode is not stalled
    // and no redirect is under way. A flush consumes it too (decode receives
    // a bubble instead), so a flushed instruction is never re-presented.
    assign transfer  = avail && !PCSrcE && !StallD;

    // ------------------------------------------------------------------
    // State register (FSM, PC, buffer)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= FETCH_REQ;
            pcf_q       <= RESET_PC;
            discard_q   <= 1'b0;
            buf_instr_q <= NOP_INSTR;
        end else begin
            state_q     <= state_d;
            pcf_q       <= pcf_d;
            discard_q   <= discard_d;
            buf_instr_q <= buf_instr_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        discard_d   = discard_q;
        buf_instr_d = buf_instr_q;
        case (state_q)
            FETCH_REQ: begin
                // A redirect coinciding with acceptance still leaves the old
                // request in flight, so its response must be discarded.
                if (imem_ready) begin
                    state_d   = FETCH_WAIT;
                    discard_d = PCSrcE;
                end
            end
            FETCH_WAIT: begin
                if (imem_rvalid) begin
                    state_d   = FETCH_REQ;
                    discard_d = 1'b0;
                    // Only a decode stall leaves a good response unconsumed.
                    if (!discard_q && !PCSrcE && !transfer) begin
                        state_d     = FETCH_FULL;
                        buf_instr_d = imem_rdata;
                    end
                end else if (PCSrcE) begin
                    discard_d = 1'b1;
                end
            end
            FETCH_FULL: begin
                if (PCSrcE || transfer) begin
                    state_d = FETCH_REQ;
                end
            end
            default: begin
                state_d = FETCH_REQ;
            end
        endcase
    end

    // PC: redirect beats everything (including StallF); otherwise advance
    // only when the current instruction leaves the fetch stage.
    always_comb begin
        pcf_d = pcf_q;
        if (PCSrcE) begin
            pcf_d = PCTargetE & ALIGN_MASK;
        end else if (transfer && !StallF) begin
            pcf_d = pcf_plus4;
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        imem_req  = rst_n && (state_q == FETCH_REQ);
        imem_addr = pcf_q;
    end

    if_id_reg #(
        .XLEN      (XLEN),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall_i    (StallD),
        .flush_i    (FlushD),
        .load_i     (transfer),
        .instr_i    (src_instr),
        .pc_i       (pcf_q),
        .pc_plus4_i (pcf_plus4),
        .instr_o    (InstrD),
        .pc_o       (PCD),
        .pc_plus4_o (PCPlus4D),
        .valid_o    (ValidD)
    );

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        StallF = 1'b0;
    logic        StallD = 1'b0;
    logic        FlushD = 1'b0;
    logic        PCSrcE = 1'b0;
    logic [31:0] PCTargetE = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'hDEAD_BEEF;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t sbq[$];

    fetch_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .StallF      (StallF),
        .StallD      (StallD),
        .FlushD      (FlushD),
        .PCSrcE      (PCSrcE),
        .PCTargetE   (PCTargetE),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .InstrD      (InstrD),
        .PCD         (PCD),
        .PCPlus4D    (PCPlus4D),
        .ValidD      (ValidD)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return 32'hA500_0000 | a;
    endfunction

    function automatic exp_t mk(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = memf(pc);
        return e;
    endfunction

    // Instruction memory: accepts when ready, answers one cycle later unless
    // responses are held back with rsp_en=0.
    logic        mem_busy = 1'b0;
    logic [31:0] mem_addr = '0;
    logic        rsp_en = 1'b1;

    always @(posedge clk) begin
        if (imem_rvalid) mem_busy = 1'b0;
        if (imem_req && imem_ready) begin
            mem_busy = 1'b1;
            mem_addr = imem_addr;
        end
        #1;
        imem_rvalid = mem_busy && rsp_en;
        imem_rdata  = (mem_busy && rsp_en) ? memf(mem_addr) : 32'hDEAD_BEEF;
    end

    // Scoreboard: every newly loaded valid instruction in decode is matched
    // against the oldest expectation.
    logic mon_stall;
    logic mon_rst;
    exp_t mon_e;

    always @(posedge clk) begin
        mon_stall = StallD;
        mon_rst   = rst_n;
        #1;
        if (mon_rst && ValidD === 1'b1 && !mon_stall) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got pc=%h instr=%h, required no instruction", PCD, InstrD);
            end else begin
                mon_e = sbq.pop_front();
                if (PCD !== mon_e.pc || InstrD !== mon_e.instr || PCPlus4D !== mon_e.pc + 32'd4) begin
                    errors++;
                    $display("FAIL sb_decode: got pc=%h instr=%h pc4=%h, required pc=%h instr=%h pc4=%h",
                             PCD, InstrD, PCPlus4D, mon_e.pc, mon_e.instr, mon_e.pc + 32'd4);
                end else begin
                    $display("decode pc=%h instr=%h", PCD, InstrD);
                end
            end
        end
    end

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0; imem_ready = 1'b0; rsp_en = 1'b1;
        StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
        repeat (2) @(negedge clk);
        sbq.delete();
        rst_n = 1'b1;
    endtask

    task automatic check_empty(input string name);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL %s_missing: got %0d pending, required 0", name, sbq.size());
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst_n = 1'b0; imem_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (InstrD !== NOP) begin errors++; $display("FAIL rst_instr: got %h required %h", InstrD, NOP); end
        checks++; if (PCD !== 32'h0) begin errors++; $display("FAIL rst_pcd: got %h required 0", PCD); end
        checks++; if (PCPlus4D !== 32'h0) begin errors++; $display("FAIL rst_pc4: got %h required 0", PCPlus4D); end
        checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", ValidD); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b required 0", imem_req); end
        rst_n = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++; $display("FAIL rst_first_req: got req=%b addr=%h required req=1 addr=0", imem_req, imem_addr);
        end
        $display("reset checked");
    endtask

    task automatic test_throughput;
        do_reset();
        imem_ready = 1'b1;
        sbq.push_back(mk(32'h0)); sbq.push_back(mk(32'h4));
        sbq.push_back(mk(32'h8)); sbq.push_back(mk(32'hC));
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (ValidD !== ((i % 2) == 0)) begin
                errors++; $display("FAIL tp_valid_%0d: got %b required %b", i, ValidD, (i % 2) == 0);
            end
            if (i == 0) begin
                checks++;
                if (InstrD !== 32'h0050_0093 || PCD !== 32'h0) begin
                    errors++; $display("FAIL tp_first: got instr=%h pc=%h required instr=00500093 pc=0", InstrD, PCD);
                end
            end
            if (i == 2) begin
                checks++;
                if (PCD !== 32'h4) begin errors++; $display("FAIL tp_second_pc: got %h required 4", PCD); end
            end
        end
        imem_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_empty("tp");
    endtask

    task automatic test_redirect_req;
        do_reset();
        PCSrcE = 1'b1; PCTargetE = 32'h0000_0200; StallF = 1'b1;
        @(negedge clk);
        PCSrcE = 1'b0; StallF = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h200 || ValidD !== 1'b0) begin
                errors++; $display("FAIL rr_hold_%0d: got req=%b addr=%h valid=%b required req=1 addr=00000200 valid=0",
                                   i, imem_req, imem_addr, ValidD);
            end
            @(negedge clk);
        end
        sbq.push_back(mk(32'h200));
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_empty("rr");
    endtask

    task automatic test_redirect_accept;
        do_reset();
        imem_ready = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h0000_0040;
        @(negedge clk);
        PCSrcE = 1'b0;
        @(negedge clk);
        checks++;
        if (ValidD !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
            errors++; $display("FAIL ra_drop: got valid=%b req=%b addr=%h required valid=0 req=1 addr=00000040",
                               ValidD, imem_req, imem_addr);
        end
        sbq.push_back(mk(32'h40));
        @(negedge clk);
        imem_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_empty("ra");
    endtask

    task automatic test_redirect_wait;
        do_reset();
        rsp_en = 1'b0; imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'h0000_0102;
        @(negedge clk);
        PCSrcE = 1'b0; rsp_en = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || ValidD !== 1'b0) begin
            errors++; $display("FAIL rw_wait: got req=%b valid=%b required req=0 valid=0", imem_req, ValidD);
        end
        @(negedge clk);
        checks++;
        if (ValidD !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            errors++; $display("FAIL rw_drop: got valid=%b req=%b addr=%h required valid=0 req=1 addr=00000100",
                               ValidD, imem_req, imem_addr);
        end
        sbq.push_back(mk(32'h100));
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_empty("rw");
    endtask

    task automatic test_stall;
        do_reset();
        imem_ready = 1'b1;
        sbq.push_back(mk(32'h0));
        repeat (2) @(negedge clk);
        StallD = 1'b1; StallF = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (InstrD !== 32'h0050_0093 || PCD !== 32'h0 || ValidD !== 1'b1) begin
                errors++; $display("FAIL st_hold_%0d: got instr=%h pc=%h valid=%b required instr=00500093 pc=0 valid=1",
                                   i, InstrD, PCD, ValidD);
            end
            if (i >= 1) begin
                checks++;
                if (imem_req !== 1'b0) begin errors++; $display("FAIL st_noreq_%0d: got %b required 0", i, imem_req); end
            end
            if (i < 3) @(negedge clk);
        end
        StallD = 1'b0; StallF = 1'b0;
        sbq.push_back(mk(32'h4));
        @(negedge clk);
        checks++;
        if (ValidD !== 1'b1 || PCD !== 32'h4 || imem_req !== 1'b1 || imem_addr !== 32'h8) begin
            errors++; $display("FAIL st_release: got valid=%b pcd=%h req=%b addr=%h required valid=1 pcd=4 req=1 addr=8",
                               ValidD, PCD, imem_req, imem_addr);
        end
        repeat (2) @(negedge clk);
        check_empty("st");
    endtask

    task automatic test_flush;
        do_reset();
        imem_ready = 1'b1;
        @(negedge clk);
        FlushD = 1'b1; imem_ready = 1'b0;
        @(negedge clk);
        FlushD = 1'b0;
        checks++;
        if (InstrD !== NOP || ValidD !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h4) begin
            errors++; $display("FAIL fl_bubble: got instr=%h valid=%b req=%b addr=%h required instr=%h valid=0 req=1 addr=4",
                               InstrD, ValidD, imem_req, imem_addr, NOP);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (ValidD !== 1'b0) begin errors++; $display("FAIL fl_again: got valid=%b required 0", ValidD); end
        check_empty("fl");
    endtask

    task automatic test_reset_mid;
        do_reset();
        PCSrcE = 1'b1; PCTargetE = 32'h0000_0080;
        @(negedge clk);
        PCSrcE = 1'b0; imem_ready = 1'b1; rsp_en = 1'b0;
        @(negedge clk);
        imem_ready = 1'b0; rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL rm_req_in_reset: got %b required 0", imem_req); end
        @(negedge clk);
        rst_n = 1'b1; rsp_en = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++; $display("FAIL rm_pc_reset: got req=%b addr=%h required req=1 addr=0", imem_req, imem_addr);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (ValidD !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++; $display("FAIL rm_late_rvalid: got valid=%b req=%b addr=%h required valid=0 req=1 addr=0",
                               ValidD, imem_req, imem_addr);
        end
        sbq.push_back(mk(32'h0));
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_empty("rm");
    endtask

    initial begin
        test_reset();
        test_throughput();
        test_redirect_req();
        test_redirect_accept();
        test_redirect_wait();
        test_stall();
        test_flush();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish before 100000");
        $fatal(1, "watchdog expired");
    end

endmodule
